// File: rtl/seg_display_sched.sv
// Display scheduler for the 6-digit multiplexed seven-segment driver.
// It shares the display between a persistent base value and a one-shot
// message. The message is held on the display for MSG_HOLD_MS cycles.
// In base mode it applies leading-zero blanking and per-digit blinking.
// All timing runs off CLK_1K, so one cycle is one millisecond.
module seg_display_sched #(
    parameter int MSG_HOLD_MS   = 2000,
    parameter int BLINK_HALF_MS = 250
) (
    input  logic        FPGA_nRST,
    input  logic        CLK_1K,
    input  logic [23:0] base_number,
    input  logic [5:0]  base_dot,
    input  logic [5:0]  blink_mask,
    input  logic        lz_en,
    input  logic        msg_req,
    input  logic [23:0] msg_number,
    input  logic [5:0]  msg_dot,
    input  logic [5:0]  msg_hide,
    output logic        msg_ack,
    output logic        msg_active,
    output logic [23:0] Number,
    output logic [5:0]  Hide,
    output logic [5:0]  Dot
);

    localparam logic [11:0] HOLD_LAST  = 12'(MSG_HOLD_MS - 1);
    localparam logic [9:0]  BLINK_LAST = 10'(BLINK_HALF_MS - 1);

    typedef enum logic {
        ST_BASE = 1'b0,
        ST_MSG  = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic        req_d_reg;
    logic [11:0] hold_cnt_reg, hold_cnt_next;
    logic [9:0]  blink_cnt_reg, blink_cnt_next;
    logic        blink_phase_reg, blink_phase_next;
    logic [23:0] msg_number_reg, msg_number_next;
    logic [5:0]  msg_dot_reg, msg_dot_next;
    logic [5:0]  msg_hide_reg, msg_hide_next;
    logic [23:0] number_reg, number_next;
    logic [5:0]  hide_reg, hide_next;
    logic [5:0]  dot_reg, dot_next;
    logic        msg_ack_reg, msg_ack_next;
    logic        msg_active_reg, msg_active_next;

    logic        req_rise;
    logic [5:0]  lz_hide;
    logic [5:0]  base_hide;

    // A level held high only counts once: act on the 0->1 transition.
    assign req_rise = msg_req & ~req_d_reg;

    // Digit i is blank when every nibble from i up to the top is zero.
    // The rightmost digit is never blanked, so a value of zero shows "0".
    assign lz_hide[0] = 1'b0;
    for (genvar gi = 1; gi < 6; gi++) begin : g_lz
        assign lz_hide[gi] = lz_en & (base_number[23:4*gi] == '0);
    end

    assign base_hide = lz_hide | (blink_mask & {6{blink_phase_reg}});

    // The blink generator runs in both states, so the blink stays in step
    // across message interruptions.
    always_comb begin
        blink_cnt_next   = blink_cnt_reg + 10'd1;
        blink_phase_next = blink_phase_reg;
        if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next   = 10'd0;
            blink_phase_next = ~blink_phase_reg;
        end
    end

    // Next-state and output selection. A new request always wins, even on
    // the timeout edge, and the latest message replaces any current one.
    always_comb begin
        state_next      = state_reg;
        hold_cnt_next   = hold_cnt_reg;
        msg_number_next = msg_number_reg;
        msg_dot_next    = msg_dot_reg;
        msg_hide_next   = msg_hide_reg;
        number_next     = base_number;
        hide_next       = base_hide;
        dot_next        = base_dot;
        msg_ack_next    = 1'b0;
        msg_active_next = msg_active_reg;

        if (req_rise) begin
            state_next      = ST_MSG;
            hold_cnt_next   = 12'd0;
            msg_number_next = msg_number;
            msg_dot_next    = msg_dot;
            msg_hide_next   = msg_hide;
            number_next     = msg_number;
            hide_next       = msg_hide;
            dot_next        = msg_dot;
            msg_ack_next    = 1'b1;
            msg_active_next = 1'b1;
        end else begin
            case (state_reg)
                ST_BASE: begin
                    msg_active_next = 1'b0;
                end
                ST_MSG: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_next      = ST_BASE;
                        msg_active_next = 1'b0;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 12'd1;
                        number_next   = msg_number_reg;
                        hide_next     = msg_hide_reg;
                        dot_next      = msg_dot_reg;
                    end
                end
                default: begin
                    state_next      = ST_BASE;
                    msg_active_next = 1'b0;
                end
            endcase
        end
    end

    // State registers. Reset blanks the display and discards any message.
    always_ff @(posedge CLK_1K or negedge FPGA_nRST) begin
        if (!FPGA_nRST) begin
            state_reg       <= ST_BASE;
            req_d_reg       <= 1'b0;
            hold_cnt_reg    <= 12'd0;
            blink_cnt_reg   <= 10'd0;
            blink_phase_reg <= 1'b0;
            msg_number_reg  <= 24'd0;
            msg_dot_reg     <= 6'd0;
            msg_hide_reg    <= 6'd0;
            number_reg      <= 24'd0;
            hide_reg        <= 6'b111111;
            dot_reg         <= 6'd0;
            msg_ack_reg     <= 1'b0;
            msg_active_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            req_d_reg       <= msg_req;
            hold_cnt_reg    <= hold_cnt_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
            msg_number_reg  <= msg_number_next;
            msg_dot_reg     <= msg_dot_next;
            msg_hide_reg    <= msg_hide_next;
            number_reg      <= number_next;
            hide_reg        <= hide_next;
            dot_reg         <= dot_next;
            msg_ack_reg     <= msg_ack_next;
            msg_active_reg  <= msg_active_next;
        end
    end

    assign Number     = number_reg;
    assign Hide       = hide_reg;
    assign Dot        = dot_reg;
    assign msg_ack    = msg_ack_reg;
    assign msg_active = msg_active_reg;

endmodule

// File: tb/tb_seg_display_sched.sv
// Bench for seg_display_sched: reset values, a table of base-mode vectors,
// blink timing, message hold/retrigger/reset sequences, then random traffic
// compared every cycle against a time-based reference model.
`timescale 1ns/1ps
module tb_seg_display_sched;

    localparam int HOLD  = 10;
    localparam int BLINK = 4;

    logic        FPGA_nRST;
    logic        CLK_1K;
    logic [23:0] base_number;
    logic [5:0]  base_dot;
    logic [5:0]  blink_mask;
    logic        lz_en;
    logic        msg_req;
    logic [23:0] msg_number;
    logic [5:0]  msg_dot;
    logic [5:0]  msg_hide;
    logic        msg_ack;
    logic        msg_active;
    logic [23:0] Number;
    logic [5:0]  Hide;
    logic [5:0]  Dot;

    seg_display_sched #(
        .MSG_HOLD_MS  (HOLD),
        .BLINK_HALF_MS(BLINK)
    ) dut (
        .FPGA_nRST  (FPGA_nRST),
        .CLK_1K     (CLK_1K),
        .base_number(base_number),
        .base_dot   (base_dot),
        .blink_mask (blink_mask),
        .lz_en      (lz_en),
        .msg_req    (msg_req),
        .msg_number (msg_number),
        .msg_dot    (msg_dot),
        .msg_hide   (msg_hide),
        .msg_ack    (msg_ack),
        .msg_active (msg_active),
        .Number     (Number),
        .Hide       (Hide),
        .Dot        (Dot)
    );

    initial CLK_1K = 1'b0;
    always #5 CLK_1K = ~CLK_1K;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    endtask

    // Reference model: edges counted since reset release; a message owns the
    // display until edge (capture edge + HOLD) unless a newer request comes.
    int          m_edge;
    logic        m_req_d;
    logic        m_active;
    int          m_until;
    logic [23:0] m_lnum;
    logic [5:0]  m_ldot, m_lhide;
    logic [23:0] e_num;
    logic [5:0]  e_hide, e_dot;
    logic        e_ack, e_active;

    task automatic model_reset();
        m_edge = 0; m_req_d = 1'b0; m_active = 1'b0; m_until = 0;
        m_lnum = 24'd0; m_ldot = 6'd0; m_lhide = 6'd0;
        e_num = 24'd0; e_hide = 6'h3F; e_dot = 6'd0; e_ack = 1'b0; e_active = 1'b0;
    endtask

    task automatic model_edge();
        logic       rise;
        logic       phase;
        logic       found;
        int         k;
        logic [5:0] lzh;
        m_edge++;
        rise    = msg_req && !m_req_d;
        m_req_d = msg_req;
        phase   = (((m_edge - 1) / BLINK) % 2) == 1;
        if (rise) begin
            m_active = 1'b1;
            m_until  = m_edge + HOLD;
            m_lnum   = msg_number;
            m_ldot   = msg_dot;
            m_lhide  = msg_hide;
            e_ack    = 1'b1;
        end else begin
            e_ack = 1'b0;
            if (m_active && m_edge >= m_until) m_active = 1'b0;
        end
        e_active = m_active;
        if (m_active) begin
            e_num = m_lnum; e_hide = m_lhide; e_dot = m_ldot;
        end else begin
            k = 0; found = 1'b0;
            for (int i = 5; i >= 1; i--) begin
                if (base_number[i*4 +: 4] != 4'd0) found = 1'b1;
                if (!found) k++;
            end
            lzh    = lz_en ? 6'(((1 << k) - 1) << (6 - k)) : 6'd0;
            e_hide = lzh | (blink_mask & {6{phase}});
            e_num  = base_number;
            e_dot  = base_dot;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK_1K);
        #1;
        check("model_number", 32'(Number), 32'(e_num));
        check("model_hide", 32'(Hide), 32'(e_hide));
        check("model_dot", 32'(Dot), 32'(e_dot));
        check("model_ack", 32'(msg_ack), 32'(e_ack));
        check("model_active", 32'(msg_active), 32'(e_active));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_number"}, 32'(Number), 32'h0);
        check({tag, "_hide"}, 32'(Hide), 32'h3F);
        check({tag, "_dot"}, 32'(Dot), 32'h0);
        check({tag, "_ack"}, 32'(msg_ack), 32'h0);
        check({tag, "_active"}, 32'(msg_active), 32'h0);
    endtask

    task automatic do_reset();
        FPGA_nRST = 1'b0;
        #1;
        model_reset();
        check_reset_vals("rst");
        @(negedge CLK_1K);
        FPGA_nRST = 1'b1;
    endtask

    // One message, optionally retriggered at sample index pulse2_at.
    // Sample 0 is the capture edge.
    task automatic run_msg(input int pulse2_at, input logic [23:0] n2,
                           output int act_cnt, output int ack_cnt, output int first_low);
        act_cnt = 0; ack_cnt = 0; first_low = -1;
        msg_number = 24'hABCDEF; msg_hide = 6'b100000; msg_dot = 6'h3E;
        msg_req = 1'b1;
        step();
        check("cap_number", 32'(Number), 32'hABCDEF);
        check("cap_hide", 32'(Hide), 32'h20);
        check("cap_dot", 32'(Dot), 32'h3E);
        check("cap_ack", 32'(msg_ack), 32'h1);
        act_cnt += int'(msg_active);
        ack_cnt += int'(msg_ack);
        for (int i = 1; i < 40; i++) begin
            msg_req = (i == pulse2_at);
            if (i == pulse2_at) msg_number = n2;
            step();
            if (i == pulse2_at) begin
                check("retrig_number", 32'(Number), 32'(n2));
                check("retrig_ack", 32'(msg_ack), 32'h1);
            end
            act_cnt += int'(msg_active);
            ack_cnt += int'(msg_ack);
            if (!msg_active && first_low < 0) first_low = i;
        end
        msg_req = 1'b0;
        $display("msg sequence retrig_at=%0d active_cycles=%0d acks=%0d first_base=%0d",
                 pulse2_at, act_cnt, ack_cnt, first_low);
    endtask

    typedef struct {
        logic [23:0] bn;
        logic        lz;
        logic [5:0]  dot;
        logic [23:0] exp_num;
        logic [5:0]  exp_hide;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int act_cnt, ack_cnt, first_low, acks;
        int z;

        vecs[0] = '{24'h001234, 1'b1, 6'h15, 24'h001234, 6'b110000};
        vecs[1] = '{24'h000000, 1'b1, 6'h3F, 24'h000000, 6'b111110};
        vecs[2] = '{24'h000000, 1'b0, 6'h00, 24'h000000, 6'b000000};
        vecs[3] = '{24'h100000, 1'b1, 6'h2A, 24'h100000, 6'b000000};
        vecs[4] = '{24'h000001, 1'b1, 6'h01, 24'h000001, 6'b111110};
        vecs[5] = '{24'h0F0000, 1'b1, 6'h20, 24'h0F0000, 6'b100000};
        vecs[6] = '{24'h00A000, 1'b0, 6'h0C, 24'h00A000, 6'b000000};

        FPGA_nRST = 1'b0;
        base_number = 24'h001234; base_dot = 6'h15; blink_mask = 6'd0; lz_en = 1'b1;
        msg_req = 1'b0; msg_number = 24'd0; msg_dot = 6'd0; msg_hide = 6'd0;
        model_reset();
        @(negedge CLK_1K);
        @(negedge CLK_1K);
        check_reset_vals("init");
        FPGA_nRST = 1'b1;

        // Base-mode vectors: leading-zero blanking and pass-through.
        for (int i = 0; i < 7; i++) begin
            base_number = vecs[i].bn;
            lz_en       = vecs[i].lz;
            base_dot    = vecs[i].dot;
            step();
            check("vec_number", 32'(Number), 32'(vecs[i].exp_num));
            check("vec_hide", 32'(Hide), 32'(vecs[i].exp_hide));
            check("vec_dot", 32'(Dot), 32'(vecs[i].dot));
            $display("vector %0d base=%06h lz=%0d -> Number=%06h Hide=%02h Dot=%02h",
                     i, vecs[i].bn, vecs[i].lz, Number, Hide, Dot);
        end

        // Blink: 4 edges shown, 4 edges blanked, counted from reset release.
        blink_mask = 6'b000011; lz_en = 1'b0; base_number = 24'h123456;
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            step();
            check("blink_hide", 32'(Hide), ((((e - 1) / 4) % 2) == 1) ? 32'h3 : 32'h0);
        end
        $display("blink sequence 16 edges done");

        // Message hold, retrigger at hold_cnt=7, retrigger exactly at timeout.
        run_msg(-1, 24'h0, act_cnt, ack_cnt, first_low);
        check("single_active_cycles", 32'(act_cnt), 32'd10);
        check("single_acks", 32'(ack_cnt), 32'd1);
        check("single_first_base", 32'(first_low), 32'd10);
        check("single_back_number", 32'(Number), 32'h123456);
        run_msg(8, 24'h111111, act_cnt, ack_cnt, first_low);
        check("retrig7_active_cycles", 32'(act_cnt), 32'd18);
        check("retrig7_acks", 32'(ack_cnt), 32'd2);
        check("retrig7_first_base", 32'(first_low), 32'd18);
        run_msg(10, 24'h222222, act_cnt, ack_cnt, first_low);
        check("retrig9_active_cycles", 32'(act_cnt), 32'd20);
        check("retrig9_acks", 32'(ack_cnt), 32'd2);
        check("retrig9_first_base", 32'(first_low), 32'd20);

        // Reset mid-message, then msg_req held high through release.
        msg_number = 24'hABCDEF; msg_hide = 6'b100000; msg_dot = 6'h3E;
        msg_req = 1'b1;
        step();
        msg_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        FPGA_nRST = 1'b0;
        #1;
        check_reset_vals("midmsg_rst");
        model_reset();
        msg_req = 1'b1; msg_number = 24'h555555;
        @(negedge CLK_1K);
        FPGA_nRST = 1'b1;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 0) check("rel_first_ack", 32'(msg_ack), 32'h1);
            acks += int'(msg_ack);
        end
        check("rel_total_acks", 32'(acks), 32'd1);
        $display("reset-release capture acks=%0d", acks);
        msg_req = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                z = $urandom_range(0, 6);
                base_number = 24'($urandom) >> (4 * z);
                lz_en       = 1'($urandom);
                blink_mask  = 6'($urandom);
                base_dot    = 6'($urandom);
            end
            if (msg_req) begin
                if ($urandom_range(0, 1) == 0) msg_req = 1'b0;
            end else if ($urandom_range(0, 19) == 0) begin
                msg_req    = 1'b1;
                msg_number = 24'($urandom);
                msg_dot    = 6'($urandom);
                msg_hide   = 6'($urandom);
            end
            step();
            if (msg_ack)
                $display("random capture at step %0d Number=%06h Hide=%02h", i, Number, Hide);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
